bp_chooser_ghr: RTL and testbench

//  Next-generation tournament chooser for the frontend branch predictor. Holds a table of saturating

---
 rtl/bp_chooser_ghr.sv | 163 ++++++++++++++++
 tb/tb_bp_chooser_ghr.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_chooser_ghr.sv
// Tournament chooser: saturating counters indexed by PC^GHR pick local vs global prediction per fetch slot.
// Predict is combinational; updates and GHR shifts land next cycle; a clear engine rewrites one row per cycle.
module bp_chooser_ghr #(
  parameter int VLEN            = 64,
  parameter int INSTR_PER_FETCH = 2,
  parameter int NR_ENTRIES      = 1024,
  parameter int CTR_WIDTH       = 2,
  parameter int GHR_LEN         = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic [INSTR_PER_FETCH-1:0] lbp_valid_i,
  input  logic [INSTR_PER_FETCH-1:0] lbp_taken_i,
  input  logic [INSTR_PER_FETCH-1:0] gbp_valid_i,
  input  logic [INSTR_PER_FETCH-1:0] gbp_taken_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [INSTR_PER_FETCH-1:0] pred_sel_glb_o,
  output logic [GHR_LEN-1:0]         ghr_o,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  input  logic                       upd_lbp_taken_i,
  input  logic                       upd_gbp_taken_i,
  input  logic [GHR_LEN-1:0]         upd_ghr_i,
  output logic                       busy_o
);

  localparam int ROW_BITS = $clog2(INSTR_PER_FETCH);
  localparam int SLOT_W   = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int IDX      = $clog2(NR_ENTRIES);
  localparam int ROW_W    = INSTR_PER_FETCH * CTR_WIDTH;
  localparam logic [CTR_WIDTH-1:0] INIT = CTR_WIDTH'(2 ** (CTR_WIDTH - 1) - 1);
  localparam logic [CTR_WIDTH-1:0] CMAX = '1;
  localparam logic [IDX-1:0]       LAST = IDX'(NR_ENTRIES - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [IDX-1:0]     clr_idx_q, clr_idx_d;
  logic [GHR_LEN-1:0] ghr_q, ghr_shift;
  logic [ROW_W-1:0]   tbl [NR_ENTRIES];

  logic               busy;
  logic               upd_acc;
  logic               lc, gc;
  logic [IDX-1:0]     pred_row, upd_row;
  logic [SLOT_W-1:0]  upd_slot;
  logic [ROW_W-1:0]   prow, urow;
  logic [CTR_WIDTH-1:0] old_ctr, new_ctr;
  logic               unused_pc;

  // History folded onto the index: zero-extended when short, truncated when long.
  function automatic logic [IDX-1:0] hist_idx(input logic [GHR_LEN-1:0] g);
    logic [IDX+GHR_LEN-1:0] ext;
    ext = {{IDX{1'b0}}, g};
    return ext[IDX-1:0];
  endfunction

  assign unused_pc = ^{vpc_i, upd_pc_i};

  assign busy     = (state_q == CLEAR);
  assign busy_o   = busy;
  assign ghr_o    = ghr_q;
  assign pred_row = vpc_i[1+ROW_BITS +: IDX] ^ hist_idx(ghr_q);
  assign upd_row  = upd_pc_i[1+ROW_BITS +: IDX] ^ hist_idx(upd_ghr_i);

  generate
    if (ROW_BITS > 0) begin : g_slot
      assign upd_slot = upd_pc_i[1 +: SLOT_W];
    end else begin : g_noslot
      assign upd_slot = '0;
    end
    if (GHR_LEN == 1) begin : g_ghr1
      assign ghr_shift = upd_taken_i;
    end else begin : g_ghrn
      assign ghr_shift = {ghr_q[GHR_LEN-2:0], upd_taken_i};
    end
  endgenerate

  assign upd_acc = upd_valid_i & ~debug_mode_i & ~busy & ~flush_bp_i & ~rst_i;
  assign lc      = (upd_lbp_taken_i == upd_taken_i);
  assign gc      = (upd_gbp_taken_i == upd_taken_i);
  assign urow    = tbl[upd_row];
  assign old_ctr = urow[upd_slot*CTR_WIDTH +: CTR_WIDTH];

  always_comb begin
    new_ctr = old_ctr;
    if (gc && !lc && old_ctr != CMAX)
      new_ctr = old_ctr + 1'b1;
    else if (lc && !gc && old_ctr != '0)
      new_ctr = old_ctr - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (flush_bp_i) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        if (flush_bp_i)
          clr_idx_d = '0;
        else if (clr_idx_q == LAST)
          state_d = IDLE;
        else
          clr_idx_d = clr_idx_q + 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_bp_i)
      ghr_q <= '0;
    else if (upd_acc)
      ghr_q <= ghr_shift;
  end

  // Clear and update never overlap: updates are refused while busy.
  always_ff @(posedge clk_i) begin
    if (busy)
      tbl[clr_idx_q] <= {INSTR_PER_FETCH{INIT}};
    else if (upd_acc)
      tbl[upd_row][upd_slot*CTR_WIDTH +: CTR_WIDTH] <= new_ctr;
  end

  assign prow = tbl[pred_row];

  always_comb begin
    logic sel;
    sel            = 1'b0;
    pred_valid_o   = '0;
    pred_taken_o   = '0;
    pred_sel_glb_o = '0;
    if (!busy) begin
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
        sel               = prow[i*CTR_WIDTH + CTR_WIDTH - 1];
        pred_sel_glb_o[i] = sel;
        pred_valid_o[i]   = sel ? gbp_valid_i[i] : lbp_valid_i[i];
        pred_taken_o[i]   = sel ? gbp_taken_i[i] : lbp_taken_i[i];
      end
    end
  end

endmodule

// File: tb/tb_bp_chooser_ghr.sv
// Bench for bp_chooser_ghr: random and directed stimulus checked against a table-of-integers model.
module tb_bp_chooser_ghr;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_bp_i, debug_mode_i;
  logic [63:0] vpc_i;
  logic [1:0]  lbp_valid_i, lbp_taken_i, gbp_valid_i, gbp_taken_i;
  logic [1:0]  pred_valid_o, pred_taken_o, pred_sel_glb_o;
  logic [7:0]  ghr_o;
  logic        upd_valid_i;
  logic [63:0] upd_pc_i;
  logic        upd_taken_i, upd_lbp_taken_i, upd_gbp_taken_i;
  logic [7:0]  upd_ghr_i;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  int mctr [1024][2];
  int mghr;
  int mclr;

  always #5 clk_i = ~clk_i;

  bp_chooser_ghr dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
    .vpc_i(vpc_i), .lbp_valid_i(lbp_valid_i), .lbp_taken_i(lbp_taken_i),
    .gbp_valid_i(gbp_valid_i), .gbp_taken_i(gbp_taken_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_sel_glb_o(pred_sel_glb_o),
    .ghr_o(ghr_o), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_lbp_taken_i(upd_lbp_taken_i), .upd_gbp_taken_i(upd_gbp_taken_i),
    .upd_ghr_i(upd_ghr_i), .busy_o(busy_o)
  );

  function automatic logic [63:0] pc_for_row(input int row, input int slot);
    logic [63:0] p;
    p = {$urandom, $urandom};
    p = (p / 4096) * 4096 + 64'(row % 1024) * 4 + 64'(slot % 2) * 2 + 64'(p % 2);
    return p;
  endfunction

  // Expected predictor outputs from the current fetch inputs and the model table.
  function automatic logic [5:0] mpred();
    int row;
    bit sel;
    logic [1:0] v, t, s;
    v = 0; t = 0; s = 0;
    row = int'((vpc_i / 4) % 1024) ^ (mghr % 1024);
    if (mclr == 0) begin
      for (int i = 0; i < 2; i++) begin
        sel  = (mctr[row][i] >= 2);
        s[i] = sel;
        v[i] = sel ? gbp_valid_i[i] : lbp_valid_i[i];
        t[i] = sel ? gbp_taken_i[i] : lbp_taken_i[i];
      end
    end
    return {v, t, s};
  endfunction

  task automatic cyc();
    bit acc;
    int row, slot;
    acc  = upd_valid_i && !debug_mode_i && (mclr == 0) && !flush_bp_i && !rst_i;
    row  = int'((upd_pc_i / 4) % 1024) ^ (int'(upd_ghr_i) % 1024);
    slot = int'((upd_pc_i / 2) % 2);
    @(posedge clk_i);
    if (rst_i || flush_bp_i) begin
      mclr = 1024;
      mghr = 0;
      for (int r = 0; r < 1024; r++) begin
        mctr[r][0] = 1;
        mctr[r][1] = 1;
      end
    end else begin
      if (mclr > 0) mclr--;
      if (acc) begin
        if (upd_gbp_taken_i == upd_taken_i && upd_lbp_taken_i != upd_taken_i && mctr[row][slot] < 3)
          mctr[row][slot]++;
        else if (upd_lbp_taken_i == upd_taken_i && upd_gbp_taken_i != upd_taken_i && mctr[row][slot] > 0)
          mctr[row][slot]--;
        mghr = ((mghr * 2) + int'(upd_taken_i)) % 256;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst_i = 0; flush_bp_i = 0; debug_mode_i = 0; upd_valid_i = 0;
    upd_pc_i = 0; upd_taken_i = 0; upd_lbp_taken_i = 0; upd_gbp_taken_i = 0; upd_ghr_i = 0;
  endtask

  task automatic rand_fetch();
    vpc_i = {$urandom, $urandom};
    lbp_valid_i = 2'($urandom); lbp_taken_i = 2'($urandom);
    gbp_valid_i = 2'($urandom); gbp_taken_i = 2'($urandom);
  endtask

  task automatic set_update(input int row, input bit tk, input bit lt, input bit gt, input int g);
    upd_valid_i = 1; upd_pc_i = pc_for_row(row, 0); upd_taken_i = tk;
    upd_lbp_taken_i = lt; upd_gbp_taken_i = gt; upd_ghr_i = 8'(g);
  endtask

  // Fetch that hits logical row r under the current history; lbp says not-taken, gbp says taken.
  task automatic probe_row(input int r);
    vpc_i = pc_for_row((r ^ mghr) % 1024, 0);
    lbp_valid_i = 2'b11; gbp_valid_i = 2'b11; lbp_taken_i = 2'b00; gbp_taken_i = 2'b11;
  endtask

  task automatic walk_rows(input string name);
    logic [5:0] exp;
    for (int r = 0; r < 1024; r++) begin
      rand_fetch();
      vpc_i = pc_for_row(r ^ mghr, 0);
      #1;
      exp = mpred();
      checks++;
      if (pred_sel_glb_o !== 2'b00 || {pred_valid_o, pred_taken_o, pred_sel_glb_o} !== exp) begin
        failures++;
        $display("FAIL %s row %0d: got v/t/s=%b expected %b", name, r,
                 {pred_valid_o, pred_taken_o, pred_sel_glb_o}, exp);
      end
    end
  endtask

  task automatic clear_window(input string name, input int n, input bit rand_upd);
    logic [5:0] exp;
    for (int c = 0; c < n; c++) begin
      rand_fetch();
      if (rand_upd) begin
        set_update($urandom_range(0, 1023), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 255));
        upd_valid_i = 1'($urandom);
      end
      #1;
      exp = mpred();
      checks++;
      if (busy_o !== (mclr != 0) || ghr_o !== 8'(mghr) ||
          {pred_valid_o, pred_taken_o, pred_sel_glb_o} !== exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got busy=%b ghr=%h pred=%b expected busy=%b ghr=%h pred=%b",
                 name, c, busy_o, ghr_o, {pred_valid_o, pred_taken_o, pred_sel_glb_o},
                 (mclr != 0), 8'(mghr), exp);
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs(); rand_fetch();
    rst_i = 1; cyc(); rst_i = 0;
    #1;
    checks++;
    if (busy_o !== 1'b1 || pred_valid_o !== 2'b00 || pred_taken_o !== 2'b00 ||
        pred_sel_glb_o !== 2'b00 || ghr_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_values: got busy=%b v=%b t=%b s=%b ghr=%h expected 1 00 00 00 00",
               busy_o, pred_valid_o, pred_taken_o, pred_sel_glb_o, ghr_o);
    end
    clear_window("reset_clear", 1024, 1'b0);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got busy=%b expected 0", busy_o);
    end
    walk_rows("reset_rows");
  endtask

  task automatic test_counter_sat();
    bit exp_sel [5] = '{1, 1, 1, 1, 0};
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      if (k < 3) set_update(32'h20, 1, 0, 1, 0);
      else       set_update(32'h20, 1, 1, 0, 0);
      cyc();
      idle_inputs();
      probe_row(32'h20);
      #1;
      checks++;
      if (pred_sel_glb_o !== {1'b0, exp_sel[k]} || pred_taken_o !== {1'b0, exp_sel[k]} ||
          ghr_o !== 8'(mghr)) begin
        failures++;
        $display("FAIL counter_sat step %0d: got sel=%b taken=%b ghr=%h expected sel=%b taken=%b ghr=%h",
                 k, pred_sel_glb_o, pred_taken_o, ghr_o, {1'b0, exp_sel[k]}, {1'b0, exp_sel[k]}, 8'(mghr));
      end
      cyc();
    end
  endtask

  task automatic test_ghr();
    bit tk [3] = '{1, 0, 1};
    idle_inputs(); rst_i = 1; cyc(); rst_i = 0;
    clear_window("ghr_clear", 1024, 1'b0);
    for (int k = 0; k < 3; k++) begin
      set_update(32'h20, tk[k], ~tk[k], tk[k], 8'h05);
      cyc();
    end
    idle_inputs();
    vpc_i = 64'h80; lbp_valid_i = 2'b11; gbp_valid_i = 2'b11; lbp_taken_i = 2'b00; gbp_taken_i = 2'b11;
    #1;
    checks++;
    if (ghr_o !== 8'h05) begin
      failures++;
      $display("FAIL ghr_shift: got %h expected 05", ghr_o);
    end
    checks++;
    if (pred_sel_glb_o !== 2'b01 || pred_taken_o !== 2'b01) begin
      failures++;
      $display("FAIL ghr_index: got sel=%b taken=%b expected sel=01 taken=01", pred_sel_glb_o, pred_taken_o);
    end
    cyc();
  endtask

  task automatic test_flush();
    idle_inputs(); flush_bp_i = 1; cyc(); flush_bp_i = 0;
    clear_window("flush_first", 500, 1'b1);
    flush_bp_i = 1; cyc(); flush_bp_i = 0;
    #1;
    checks++;
    if (busy_o !== 1'b1 || ghr_o !== 8'h00) begin
      failures++;
      $display("FAIL flush_restart: got busy=%b ghr=%h expected busy=1 ghr=00", busy_o, ghr_o);
    end
    clear_window("flush_clear", 1024, 1'b1);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_done: got busy=%b expected 0", busy_o);
    end
    walk_rows("flush_rows");
  endtask

  task automatic test_no_effect();
    for (int k = 0; k < 7; k++) begin
      idle_inputs();
      case (k)
        0, 1, 2: begin set_update(32'h20, 1, 0, 1, 0); debug_mode_i = 1; end
        3:       set_update(32'h20, 1, 1, 1, 0);
        4:       set_update(32'h20, 0, 1, 1, 0);
        5:       set_update(32'h20, 1, 0, 0, 0);
        default: set_update(32'h20, 0, 0, 0, 0);
      endcase
      cyc();
      idle_inputs();
      probe_row(32'h20);
      #1;
      checks++;
      if (pred_sel_glb_o !== 2'b00 || ghr_o !== 8'(mghr) || (k < 3 && ghr_o !== 8'h00)) begin
        failures++;
        $display("FAIL no_effect step %0d: got sel=%b ghr=%h expected sel=00 ghr=%h", k, pred_sel_glb_o, ghr_o, 8'(mghr));
      end
      cyc();
    end
    idle_inputs(); set_update(32'h20, 0, 1, 0, 0); cyc();
    idle_inputs(); probe_row(32'h20);
    #1;
    checks++;
    if (pred_sel_glb_o !== 2'b01) begin
      failures++;
      $display("FAIL no_effect_after: got sel=%b expected 01", pred_sel_glb_o);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    set_update(32'h20, 1, 1, 0, 0);
    probe_row(32'h20);
    #1;
    checks++;
    if (pred_sel_glb_o !== 2'b01) begin
      failures++;
      $display("FAIL same_cycle_old: got sel=%b expected 01", pred_sel_glb_o);
    end
    cyc();
    idle_inputs(); probe_row(32'h20);
    #1;
    checks++;
    if (pred_sel_glb_o !== 2'b00) begin
      failures++;
      $display("FAIL same_cycle_new: got sel=%b expected 00", pred_sel_glb_o);
    end
    cyc();
  endtask

  task automatic test_random();
    logic [5:0] exp;
    int rows [8] = '{32'h20, 32'h21, 32'h3ff, 32'h000, 32'h155, 32'h2aa, 32'h0f0, 32'h30f};
    for (int c = 0; c < 3000; c++) begin
      idle_inputs(); rand_fetch();
      vpc_i = pc_for_row(rows[$urandom_range(0, 7)] ^ mghr, $urandom_range(0, 1));
      set_update(rows[$urandom_range(0, 7)], 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 1) == 1) ? mghr : $urandom_range(0, 255));
      upd_pc_i[1]  = 1'($urandom);
      upd_valid_i  = ($urandom_range(0, 3) != 0);
      debug_mode_i = ($urandom_range(0, 7) == 0);
      flush_bp_i   = ($urandom_range(0, 999) == 0);
      #1;
      exp = mpred();
      checks++;
      if (busy_o !== (mclr != 0) || ghr_o !== 8'(mghr) ||
          {pred_valid_o, pred_taken_o, pred_sel_glb_o} !== exp) begin
        failures++;
        $display("FAIL random cycle %0d: got busy=%b ghr=%h pred=%b expected busy=%b ghr=%h pred=%b",
                 c, busy_o, ghr_o, {pred_valid_o, pred_taken_o, pred_sel_glb_o},
                 (mclr != 0), 8'(mghr), exp);
      end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    mclr = 1024; mghr = 0;
    idle_inputs(); rand_fetch();
    test_reset();
    test_counter_sat();
    test_ghr();
    test_flush();
    test_no_effect();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
